// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch front end.
//   FETCH_XLEN       : width of a fetch address / instruction word
//   RV_NOP           : addi x0,x0,0, presented when no entry is valid
//   DEFAULT_RESET_PC : first fetch address after reset
//   fetch_entry_t    : one queue entry {pc, inst}
package fetch_pkg;

  localparam int          FETCH_XLEN       = 32;
  localparam logic [31:0] RV_NOP           = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [FETCH_XLEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO of fetch_entry_t with flush.
// Ports:
//   clk_i, rst_i  : clock, asynchronous active-high reset
//   flush_i       : discard all entries (wins over push/pop)
//   push_i/data_i : write data_i at tail
//   pop_i/data_o  : data_o is the head entry; pop_i advances it
//   count_o       : number of stored entries
//   full_o/empty_o: count_o == DEPTH / count_o == 0
// The caller never pushes when full without popping, nor pops when empty.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  fetch_entry_t               data_i,
  output fetch_entry_t               data_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  fetch_entry_t    mem_q [DEPTH];
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push_i) tail_d = tail_q + PW'(1);
      if (pop_i)  head_d = head_q + PW'(1);
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[tail_q] <= data_i;
  end

  assign data_o  = mem_q[head_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: PC generator plus DEPTH-entry prefetch queue presenting
// {pc, inst, snpc} to decode over valid/ready. A redirect flushes the queue
// and restarts fetch at the (word-aligned) target.
// Optional feature macro: FETCH_BYPASS_EN -- when the queue is empty the
// current fetch is presented combinationally (zero-latency path).
// Ports:
//   cpu_clk, cpu_rst           : clock, asynchronous active-high reset
//   irom_addr / irom_data      : ROM fetch address (= pc) and returned word
//   redirect_valid/redirect_pc : flush and restart request, target
//   out_valid/out_ready        : decode handshake
//   out_pc/out_inst/out_snpc   : head entry, zero/NOP when out_valid = 0
//   occupancy                  : number of queued entries
// XLEN must equal fetch_pkg::FETCH_XLEN (entry type is fixed-width).
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int              XLEN     = FETCH_XLEN,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                       cpu_clk,
  input  logic                       cpu_rst,
  output logic [XLEN-1:0]            irom_addr,
  input  logic [XLEN-1:0]            irom_data,
  input  logic                       redirect_valid,
  input  logic [XLEN-1:0]            redirect_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_pc,
  output logic [XLEN-1:0]            out_inst,
  output logic [XLEN-1:0]            out_snpc,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  logic [XLEN-1:0]            pc_q, pc_d;
  fetch_entry_t               wr_entry, head_entry;
  logic [$clog2(DEPTH+1)-1:0] count_s;
  logic                       full_s, empty_s;
  logic                       bypass_s, head_valid, pop_s, push_s;
  logic                       fifo_push, fifo_pop;

  assign wr_entry = '{pc: pc_q, inst: irom_data};

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (cpu_clk),
    .rst_i   (cpu_rst),
    .flush_i (redirect_valid),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .data_i  (wr_entry),
    .data_o  (head_entry),
    .count_o (count_s),
    .full_o  (full_s),
    .empty_o (empty_s)
  );

  always_comb begin
`ifdef FETCH_BYPASS_EN
    bypass_s = empty_s & ~redirect_valid;
`else
    bypass_s = 1'b0;
`endif
    head_valid = ~empty_s | bypass_s;
    // Redirect masks both handshake sides; out_ready is ignored that cycle.
    pop_s  = head_valid & out_ready & ~redirect_valid;
    push_s = ~redirect_valid & (~full_s | pop_s);
    // A bypassed word taken by decode is consumed without touching the FIFO.
    fifo_push = push_s & ~(bypass_s & out_ready);
    fifo_pop  = pop_s & ~bypass_s;

    pc_d = pc_q;
    if (redirect_valid) pc_d = {redirect_pc[XLEN-1:2], 2'b00};
    else if (push_s)    pc_d = pc_q + XLEN'(4);

    out_valid = head_valid;
    out_pc    = '0;
    out_inst  = RV_NOP;
    out_snpc  = '0;
    if (head_valid) begin
      if (bypass_s) begin
        out_pc   = pc_q;
        out_inst = irom_data;
      end else begin
        out_pc   = head_entry.pc;
        out_inst = head_entry.inst;
      end
      out_snpc = out_pc + XLEN'(4);
    end
  end

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) pc_q <= RESET_PC;
    else         pc_q <= pc_d;
  end

  assign irom_addr = pc_q;
  assign occupancy = count_s;

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h8000_0000;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        cpu_clk, cpu_rst;
  logic [31:0] irom_addr, irom_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid, out_ready;
  logic [31:0] out_pc, out_inst, out_snpc;
  logic [2:0]  occupancy;

  int tests = 0;
  int fails = 0;

  fetch_queue #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .cpu_clk        (cpu_clk),
    .cpu_rst        (cpu_rst),
    .irom_addr      (irom_addr),
    .irom_data      (irom_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_inst       (out_inst),
    .out_snpc       (out_snpc),
    .occupancy      (occupancy)
  );

  function automatic logic [31:0] rom_f(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'hC0DE_5A00;
  endfunction

  assign irom_data = rom_f(irom_addr);

  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of fetched pcs plus the fetch pointer.
  logic [31:0] mq[$];
  logic [31:0] mpc;

  always @(negedge cpu_clk) begin
    logic        v, pop, push;
    logic [31:0] hp;
    if (cpu_rst) begin
      mq.delete();
      mpc = RPC;
    end
    v  = (mq.size() > 0);
    hp = v ? mq[0] : 32'h0;
    chk("m_irom_addr", irom_addr, mpc);
    chk("m_out_valid", {31'b0, out_valid}, {31'b0, v});
    chk("m_out_pc", out_pc, hp);
    chk("m_out_inst", out_inst, v ? rom_f(hp) : NOP);
    chk("m_out_snpc", out_snpc, v ? hp + 32'd4 : 32'h0);
    chk("m_occupancy", {29'b0, occupancy}, mq.size());
    if (!cpu_rst) begin
      pop  = v && out_ready && !redirect_valid;
      push = !redirect_valid && (mq.size() < DEPTH || pop);
      if (redirect_valid) begin
        mq.delete();
        mpc = redirect_pc & 32'hFFFF_FFFC;
      end else begin
        if (pop) void'(mq.pop_front());
        if (push) begin
          mq.push_back(mpc);
          mpc = mpc + 32'd4;
        end
      end
    end
  end

  task automatic step();
    @(posedge cpu_clk);
    #1;
  endtask

  initial begin
    cpu_rst = 1'b1;
    out_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    repeat (2) @(posedge cpu_clk);
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_inst", out_inst, 32'h0000_0013);
    chk("rst_irom_addr", irom_addr, 32'h8000_0000);
    cpu_rst = 1'b0;
    out_ready = 1'b1;

    // Streaming at one per cycle.
    for (int i = 0; i < 8; i++) begin
      step();
      chk("stream_pc", out_pc, 32'h8000_0000 + 32'(4 * i));
      chk("stream_occ", {29'b0, occupancy}, 32'd1);
    end

    // Fill with out_ready low, then drain while continuously full.
    cpu_rst = 1'b1;
    out_ready = 1'b0;
    step();
    cpu_rst = 1'b0;
    repeat (4) step();
    chk("fill_occ4", {29'b0, occupancy}, 32'd4);
    chk("fill_addr", irom_addr, 32'h8000_0010);
    repeat (6) step();
    chk("hold_occ4", {29'b0, occupancy}, 32'd4);
    chk("hold_addr", irom_addr, 32'h8000_0010);
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      chk("drain_pc", out_pc, 32'h8000_0000 + 32'(4 * i));
      chk("drain_occ", {29'b0, occupancy}, 32'd4);
      step();
    end

    // Redirect while full; the concurrent out_ready is ignored.
    out_ready = 1'b0;
    repeat (2) step();
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0103;
    out_ready = 1'b1;
    step();
    redirect_valid = 1'b0;
    out_ready = 1'b0;
    chk("redir_occ0", {29'b0, occupancy}, 32'd0);
    chk("redir_addr", irom_addr, 32'h8000_0100);
    step();
    chk("redir_valid", {31'b0, out_valid}, 32'd1);
    chk("redir_pc", out_pc, 32'h8000_0100);

    // Address wrap at the top of the space.
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    out_ready = 1'b1;
    step();
    redirect_valid = 1'b0;
    chk("wrap_empty", {31'b0, out_valid}, 32'd0);
    step();
    chk("wrap_pc0", out_pc, 32'hFFFF_FFF8);
    step();
    chk("wrap_pc1", out_pc, 32'hFFFF_FFFC);
    step();
    chk("wrap_pc2", out_pc, 32'h0000_0000);
    chk("wrap_snpc2", out_snpc, 32'h0000_0004);

    // Asynchronous reset with three entries queued.
    out_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_1000;
    step();
    redirect_valid = 1'b0;
    repeat (3) step();
    chk("ar_occ3", {29'b0, occupancy}, 32'd3);
    #2;
    cpu_rst = 1'b1;
    #1;
    chk("ar_valid", {31'b0, out_valid}, 32'd0);
    chk("ar_occ", {29'b0, occupancy}, 32'd0);
    chk("ar_addr", irom_addr, 32'h8000_0000);
    step();
    cpu_rst = 1'b0;
    out_ready = 1'b1;
    step();
    chk("ar_resume", out_pc, 32'h8000_0000);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      out_ready = ($urandom_range(0, 3) != 0) || (i % 64 < 8) ? ((i % 64) >= 8) : 1'b0;
      if ((i % 64) >= 8) out_ready = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc = $urandom();
      step();
    end
    redirect_valid = 1'b0;
    out_ready = 1'b1;
    repeat (6) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction-fetch front end for the RV32I pipeline. It replaces the single-register fetch stage with a PC generator feeding a DEPTH-entry prefetch queue, and presents {pc, inst, snpc} to decode over a valid/ready handshake. A redirect input (branch, jump, trap or mret target) flushes the queue and restarts fetch. It sits between the instruction ROM port and the decode stage, under the pipeline top.

## Interface
Parameters:
- XLEN, 32: address and instruction width.
- DEPTH, 4: queue entries; power of two, at least 2.
- RESET_PC, 32'h8000_0000: first fetch address after reset.

Ports:
- cpu_clk  in  1  sole clock, rising edge.
- cpu_rst  in  1  asynchronous, active-high reset.
- irom_addr  out  XLEN  fetch address; equals internal pc.
- irom_data  in  XLEN  instruction at irom_addr, combinational in the same cycle.
- redirect_valid  in  1  redirect request, one-cycle pulse.
- redirect_pc  in  XLEN  redirect target; bits [1:0] are ignored and treated as 0.
- out_valid  out  1  head entry is valid.
- out_ready  in  1  decode accepts the head this cycle.
- out_pc  out  XLEN  pc of the head entry.
- out_inst  out  XLEN  instruction of the head entry.
- out_snpc  out  XLEN  out_pc + 4.
- occupancy  out  $clog2(DEPTH+1)  number of valid entries.

## Operation
- State: pc register, head/tail pointers of width $clog2(DEPTH) that wrap modulo DEPTH, and a count.
- pop = out_valid & out_ready & ~redirect_valid.
- push = ~redirect_valid & (count < DEPTH | pop).
- On push: the entry {pc, irom_data} is written at tail, tail advances, and pc <= pc + 4. XLEN arithmetic applies, so 0xFFFF_FFFC wraps to 0.
- Full with no pop: no push; pc holds and irom_addr holds.
- Full with pop in the same cycle: push and pop both occur; count stays DEPTH.
- Empty with no push: out_valid = 0.
- Redirect has priority over all other activity:
  - All entries are discarded and count <= 0.
  - pc <= {redirect_pc[XLEN-1:2], 2'b00}.
  - No push and no pop occur that cycle; an out_ready asserted in that cycle is ignored.
- When out_valid = 0: out_pc = 0, out_inst = 32'h0000_0013 (NOP), out_snpc = 0.
- occupancy equals count at all times.
- Reset values:
  - pc = irom_addr = RESET_PC.
  - count = occupancy = 0; head = tail = 0.
  - out_valid = 0, out_pc = 0, out_inst = NOP, out_snpc = 0.
- Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.

## Timing
- Fetch-to-decode latency is 1 cycle. An instruction fetched in cycle t appears at the head in cycle t+1 if the queue was empty.
- After reset release: cycle 0 fetches RESET_PC; cycle 1 has out_valid = 1 with out_pc = RESET_PC.
- Redirect pulse in cycle t: cycle t+1 fetches the target; cycle t+2 has out_valid = 1 with out_pc = target.
- Steady-state throughput is 1 instruction per cycle while out_ready = 1.
- With out_ready held at 0, the queue fills in DEPTH cycles. Thereafter pc is frozen at RESET_PC + 4·DEPTH (from reset).

## Configuration
- FETCH_BYPASS_EN defined:
  - When count = 0 and there is no redirect, out_valid = 1 combinationally with out_pc = pc and out_inst = irom_data.
  - If out_ready = 1 in that cycle, the instruction is consumed without being enqueued, and pc <= pc + 4.
  - If out_ready = 0, the instruction is pushed as normal.
  - Latency becomes 0 cycles: after reset, cycle 0 presents RESET_PC; redirect at t presents the target at t+1.
- FETCH_BYPASS_EN undefined: every instruction passes through the queue, as described above.

## Structure
- Package fetch_pkg holds:
  - fetch_entry_t, a packed struct {pc, inst}.
  - localparam RV_NOP = 32'h0000_0013.
  - localparam DEFAULT_RESET_PC.
- One sub-module, fetch_fifo: a generic synchronous FIFO of fetch_entry_t with push, pop, flush, count, full and empty.
- fetch_queue adds the pc generator, redirect priority, output gating and the optional bypass.

## Test plan
- Reset, then out_ready = 1 for 8 cycles -> out_pc = 0x8000_0000, +4, … +0x1C on consecutive cycles; occupancy ≤ 1 throughout.
- out_ready = 0 for 10 cycles -> occupancy reaches 4 at cycle 4 and holds; irom_addr frozen at 0x8000_0010; raising out_ready then drains 0x8000_0000… in order with no gap or duplicate.
- Queue full while redirect_valid = 1 with redirect_pc = 0x8000_0103 -> next cycle occupancy = 0 and irom_addr = 0x8000_0100; following cycle out_pc = 0x8000_0100; the out_ready asserted during the redirect cycle pops nothing.
- Full queue with out_ready = 1 continuous -> occupancy stays 4, one instruction per cycle; head/tail wrap verified past 2·DEPTH entries.
- redirect_pc = 0xFFFF_FFF8, out_ready = 1 -> out_pc sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- Reset asserted asynchronously mid-stream with 3 entries queued -> out_valid and occupancy drop to 0 before the next clock edge; after release, fetch resumes at RESET_PC.
